// File: rtl/fu_wb_arbiter_pkg.sv
// Shared sizing defaults, FU index constants and index helpers for the write-back arbiter.
package fu_wb_arbiter_pkg;
  localparam int N_FU_DEF = 5;
  localparam int XLEN_DEF = 32;
  localparam int RW_DEF   = 5;

  typedef enum int {
    FU_MEM = 0,
    FU_ALU = 1,
    FU_MUL = 2,
    FU_DIV = 3,
    FU_JMP = 4
  } fu_id_e;

  function automatic int wrap_inc(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction
endpackage

// File: rtl/fu_wb_arbiter_rr_arbiter.sv
// Round-robin arbiter: first set request at or after the pointer, wrapping; one-hot grant plus index.
module rr_arbiter #(
  parameter int N  = 5,
  parameter int IW = 3
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  output logic [N-1:0]  o_gnt,
  output logic [IW-1:0] o_idx,
  output logic          o_any
);
  always_comb begin
    int j;
    logic [IW-1:0] jj;
    o_gnt = '0;
    o_idx = '0;
    o_any = 1'b0;
    j     = 0;
    jj    = '0;
    for (int k = 0; k < N; k++) begin
      j = int'(i_ptr) + k;
      if (j >= N) j = j - N;
      jj = IW'(j);
      if (!o_any && i_req[jj]) begin
        o_any     = 1'b1;
        o_gnt[jj] = 1'b1;
        o_idx     = jj;
      end
    end
  end
endmodule

// File: rtl/fu_wb_arbiter.sv
// Write-back arbiter: per-FU holding slots drained round-robin onto one register-file write port.
// Optional same-cycle bypass into an empty block is enabled by defining FU_WB_BYPASS_EN.
module fu_wb_arbiter
  import fu_wb_arbiter_pkg::*;
#(
  parameter int  N_FU = N_FU_DEF,
  parameter int  XLEN = XLEN_DEF,
  parameter int  RW   = RW_DEF,
  localparam int IW   = (N_FU > 1) ? $clog2(N_FU) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_FU-1:0]    fu_finish,
  input  logic [N_FU*XLEN-1:0] fu_data,
  input  logic [N_FU*RW-1:0] fu_rd,
  input  logic               wb_ready,
  output logic               wb_valid,
  output logic [RW-1:0]      wb_rd,
  output logic [XLEN-1:0]    wb_data,
  output logic [IW-1:0]      wb_fu,
  output logic [N_FU-1:0]    slot_busy,
  output logic               ovf_err
);
  logic [N_FU-1:0] r_busy;
  logic [XLEN-1:0] r_data [N_FU];
  logic [RW-1:0]   r_rd   [N_FU];
  logic [IW-1:0]   r_ptr;
  logic            r_ovf;

  logic [N_FU-1:0] w_req, w_zero, w_gnt, w_clr, w_cap;
  logic [IW-1:0]   w_gidx, w_ptr_nxt;
  logic            w_any, w_drain, w_ovf;
  logic            w_byp;
  logic [IW-1:0]   w_bidx;
  logic [XLEN-1:0] w_bdata;
  logic [RW-1:0]   w_brd;

  // rd==0 results never request the port; they just evaporate on the next edge.
  always_comb begin
    w_req  = '0;
    w_zero = '0;
    for (int i = 0; i < N_FU; i++) begin
      w_req[i]  = r_busy[i] && (r_rd[i] != '0);
      w_zero[i] = r_busy[i] && (r_rd[i] == '0);
    end
  end

  rr_arbiter #(.N(N_FU), .IW(IW)) u_rr (
    .i_req (w_req),
    .i_ptr (r_ptr),
    .o_gnt (w_gnt),
    .o_idx (w_gidx),
    .o_any (w_any)
  );

`ifdef FU_WB_BYPASS_EN
  always_comb begin
    w_bidx  = '0;
    w_bdata = '0;
    w_brd   = '0;
    for (int i = 0; i < N_FU; i++) begin
      if (fu_finish[i]) begin
        w_bidx  = IW'(i);
        w_bdata = fu_data[i*XLEN +: XLEN];
        w_brd   = fu_rd[i*RW +: RW];
      end
    end
    w_byp = (r_busy == '0) && $onehot(fu_finish) && (w_brd != '0);
  end
`else
  assign w_byp   = 1'b0;
  assign w_bidx  = '0;
  assign w_bdata = '0;
  assign w_brd   = '0;
`endif

  always_comb begin
    w_drain   = w_any && wb_ready;
    w_clr     = w_zero | (w_drain ? w_gnt : '0);
    w_cap     = fu_finish;
    w_ptr_nxt = r_ptr;
    if (w_drain) w_ptr_nxt = IW'(wrap_inc(int'(w_gidx), N_FU));
    if (w_byp && wb_ready) begin
      w_cap[w_bidx] = 1'b0;
      w_ptr_nxt     = IW'(wrap_inc(int'(w_bidx), N_FU));
    end
    w_ovf = |(w_cap & r_busy & ~w_clr);
  end

  always_comb begin
    wb_valid = 1'b0;
    wb_rd    = '0;
    wb_data  = '0;
    wb_fu    = '0;
    if (w_byp) begin
      wb_valid = 1'b1;
      wb_rd    = w_brd;
      wb_data  = w_bdata;
      wb_fu    = w_bidx;
    end else if (w_any) begin
      wb_valid = 1'b1;
      wb_rd    = r_rd[w_gidx];
      wb_data  = r_data[w_gidx];
      wb_fu    = w_gidx;
    end
  end

  // A capture overrides a same-edge clear, so the newer result always survives.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_busy <= '0;
      r_ptr  <= '0;
      r_ovf  <= 1'b0;
      for (int i = 0; i < N_FU; i++) begin
        r_data[i] <= '0;
        r_rd[i]   <= '0;
      end
    end else begin
      r_ptr <= w_ptr_nxt;
      if (w_ovf) r_ovf <= 1'b1;
      for (int i = 0; i < N_FU; i++) begin
        if (w_cap[i]) begin
          r_busy[i] <= 1'b1;
          r_data[i] <= fu_data[i*XLEN +: XLEN];
          r_rd[i]   <= fu_rd[i*RW +: RW];
        end else if (w_clr[i]) begin
          r_busy[i] <= 1'b0;
        end
      end
    end
  end

  assign slot_busy = r_busy;
  assign ovf_err   = r_ovf;
endmodule

// File: tb/tb_fu_wb_arbiter.sv
// Scoreboard bench for fu_wb_arbiter: a slot-level reference model predicts each write-back.
module tb_fu_wb_arbiter;
  localparam int N   = 5;
  localparam int XL  = 32;
  localparam int RWW = 5;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [N-1:0]      fu_finish = '0;
  logic [N*XL-1:0]   fu_data = '0;
  logic [N*RWW-1:0]  fu_rd = '0;
  logic              wb_ready = 1'b0;
  logic              wb_valid;
  logic [RWW-1:0]    wb_rd;
  logic [XL-1:0]     wb_data;
  logic [2:0]        wb_fu;
  logic [N-1:0]      slot_busy;
  logic              ovf_err;

  always #5 clk = ~clk;

  fu_wb_arbiter #(.N_FU(N), .XLEN(XL), .RW(RWW)) dut (
    .clk       (clk),
    .rst       (rst),
    .fu_finish (fu_finish),
    .fu_data   (fu_data),
    .fu_rd     (fu_rd),
    .wb_ready  (wb_ready),
    .wb_valid  (wb_valid),
    .wb_rd     (wb_rd),
    .wb_data   (wb_data),
    .wb_fu     (wb_fu),
    .slot_busy (slot_busy),
    .ovf_err   (ovf_err)
  );

  int checks = 0;
  int failures = 0;
  int n_pushed = 0;
  int n_popped = 0;

  typedef struct {
    int            fu;
    logic [RWW-1:0] rd;
    logic [XL-1:0]  data;
  } wb_t;
  wb_t exp_q[$];
  wb_t mon_t;

  // Reference model: what each FU's holding slot contains, plus the fairness pointer.
  logic           m_busy [N];
  logic [RWW-1:0] m_rd   [N];
  logic [XL-1:0]  m_data [N];
  int             m_ptr;
  logic           m_ovf;

  // Expected DUT view for the cycle currently being driven.
  logic           e_valid = 1'b0;
  int             e_fu = 0;
  logic [RWW-1:0] e_rd = '0;
  logic [XL-1:0]  e_data = '0;
  logic [N-1:0]   e_busy = '0;
  logic           e_ovf = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h at %0t", nm, act, req, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_busy[i] = 1'b0;
      m_rd[i]   = '0;
      m_data[i] = '0;
    end
    m_ptr   = 0;
    m_ovf   = 1'b0;
    e_valid = 1'b0;
    e_fu    = 0;
    e_rd    = '0;
    e_data  = '0;
    e_busy  = '0;
    e_ovf   = 1'b0;
  endtask

  function automatic logic [N*XL-1:0] dslot(input int i, input logic [XL-1:0] v);
    logic [N*XL-1:0] t;
    t = '0;
    t[i*XL +: XL] = v;
    return t;
  endfunction

  function automatic logic [N*RWW-1:0] rslot(input int i, input logic [RWW-1:0] v);
    logic [N*RWW-1:0] t;
    t = '0;
    t[i*RWW +: RWW] = v;
    return t;
  endfunction

  // Drive one cycle, predict what the DUT shows in it, advance the model across the edge.
  task automatic step(input logic [N-1:0] fin, input logic [N*XL-1:0] dv,
                      input logic [N*RWW-1:0] rv, input logic rdy);
    int g;
    int bi;
    int s;
    bit byp;
    bit any_busy;
    logic [N-1:0] clr;
    fu_finish = fin;
    fu_data   = dv;
    fu_rd     = rv;
    wb_ready  = rdy;
    g = -1;
    for (int k = 0; k < N; k++) begin
      s = (m_ptr + k) % N;
      if (g < 0 && m_busy[s] && m_rd[s] != 0) g = s;
    end
    any_busy = 0;
    for (int i = 0; i < N; i++) if (m_busy[i]) any_busy = 1;
    byp = 0;
    bi  = 0;
`ifdef FU_WB_BYPASS_EN
    if (!any_busy && $countones(fin) == 1) begin
      for (int i = 0; i < N; i++) if (fin[i]) bi = i;
      if (rv[bi*RWW +: RWW] != 0) byp = 1;
    end
`endif
    for (int i = 0; i < N; i++) e_busy[i] = m_busy[i];
    e_ovf = m_ovf;
    if (byp) begin
      e_valid = 1'b1;
      e_fu    = bi;
      e_rd    = rv[bi*RWW +: RWW];
      e_data  = dv[bi*XL +: XL];
    end else if (g >= 0) begin
      e_valid = 1'b1;
      e_fu    = g;
      e_rd    = m_rd[g];
      e_data  = m_data[g];
    end else begin
      e_valid = 1'b0;
      e_fu    = 0;
      e_rd    = '0;
      e_data  = '0;
    end
    if (e_valid && rdy) begin
      exp_q.push_back('{fu: e_fu, rd: e_rd, data: e_data});
      n_pushed++;
    end
    for (int i = 0; i < N; i++)
      clr[i] = (m_busy[i] && m_rd[i] == 0) || (!byp && g == i && rdy);
    if (!byp && g >= 0 && rdy) m_ptr = (g + 1) % N;
    if (byp && rdy) m_ptr = (bi + 1) % N;
    for (int i = 0; i < N; i++) begin
      if (fin[i] && !(byp && rdy && i == bi)) begin
        if (m_busy[i] && !clr[i]) m_ovf = 1'b1;
        m_busy[i] = 1'b1;
        m_rd[i]   = rv[i*RWW +: RWW];
        m_data[i] = dv[i*XL +: XL];
      end else if (clr[i]) begin
        m_busy[i] = 1'b0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic rdy);
    step('0, '0, '0, rdy);
  endtask

  // Reset asserted between edges; outputs must drop without waiting for a clock.
  task automatic mid_reset();
    fu_finish = '0;
    #2 rst = 1'b1;
    #1;
    chk("rst_mid_valid", {63'd0, wb_valid}, 64'd0);
    chk("rst_mid_busy", {59'd0, slot_busy}, 64'd0);
    chk("rst_mid_data", {32'd0, wb_data}, 64'd0);
    chk("rst_mid_ovf", {63'd0, ovf_err}, 64'd0);
    model_reset();
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  always @(negedge clk) begin
    chk("wb_valid", {63'd0, wb_valid}, {63'd0, e_valid});
    chk("slot_busy", {59'd0, slot_busy}, {59'd0, e_busy});
    chk("ovf_err", {63'd0, ovf_err}, {63'd0, e_ovf});
    chk("wb_fu", {61'd0, wb_fu}, 64'(e_fu));
    chk("wb_rd", {59'd0, wb_rd}, {59'd0, e_rd});
    chk("wb_data", {32'd0, wb_data}, {32'd0, e_data});
    if (wb_valid === 1'b1 && wb_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sb_unexpected actual=write fu=%0d rd=%0d required=none at %0t",
                 wb_fu, wb_rd, $time);
      end else begin
        mon_t = exp_q.pop_front();
        n_popped++;
        chk("sb_fu", {61'd0, wb_fu}, 64'(mon_t.fu));
        chk("sb_rd", {59'd0, wb_rd}, {59'd0, mon_t.rd});
        chk("sb_data", {32'd0, wb_data}, {32'd0, mon_t.data});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N-1:0]     f;
    logic [N*XL-1:0]  d;
    logic [N*RWW-1:0] r;
    model_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", {63'd0, wb_valid}, 64'd0);
    chk("rst_busy", {59'd0, slot_busy}, 64'd0);
    chk("rst_fu", {61'd0, wb_fu}, 64'd0);
    chk("rst_rd", {59'd0, wb_rd}, 64'd0);
    chk("rst_data", {32'd0, wb_data}, 64'd0);
    chk("rst_ovf", {63'd0, ovf_err}, 64'd0);
    rst = 1'b0;

    // all five finish together, then drain in pointer order; then FU 0 and 2 together
    d = '0;
    r = '0;
    for (int i = 0; i < N; i++) begin
      d[i*XL +: XL]   = 32'h100 + i;
      r[i*RWW +: RWW] = RWW'(i + 1);
    end
    step('1, d, r, 1'b1);
    repeat (5) idle(1'b1);
    step(5'b00101, dslot(0, 32'hA0) | dslot(2, 32'hA2), rslot(0, 5'd10) | rslot(2, 5'd12), 1'b1);
    repeat (3) idle(1'b1);

    // single capture
    step(5'b00001, dslot(0, 32'h0000_00AB), rslot(0, 5'd7), 1'b1);
    repeat (2) idle(1'b1);

    // same-edge capture and drain of slot 1
    step(5'b00010, dslot(1, 32'h11), rslot(1, 5'd3), 1'b1);
    step(5'b00010, dslot(1, 32'h55), rslot(1, 5'd4), 1'b1);
    repeat (2) idle(1'b1);

    // rd==0 result vanishes without reaching the port
    step(5'b10000, dslot(4, 32'h44), rslot(4, 5'd0), 1'b0);
    repeat (2) idle(1'b0);

    // single result into an empty block (same-cycle write when bypass is built in)
    step(5'b01000, dslot(3, 32'h99), rslot(3, 5'd9), 1'b1);
    repeat (2) idle(1'b1);

    // back-pressure, then overwrite of the stalled slot
    step(5'b00100, dslot(2, 32'h22), rslot(2, 5'd6), 1'b0);
    repeat (2) idle(1'b0);
    step(5'b00100, dslot(2, 32'h77), rslot(2, 5'd8), 1'b0);
    idle(1'b0);
    repeat (2) idle(1'b1);

    // reset with slots 1 and 3 holding results
    step(5'b01010, dslot(1, 32'h1111) | dslot(3, 32'h3333), rslot(1, 5'd11) | rslot(3, 5'd13), 1'b0);
    idle(1'b0);
    mid_reset();
    repeat (2) idle(1'b1);

    for (int c = 0; c < 400; c++) begin
      if (c == 200) mid_reset();
      f = '0;
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 3) == 0) f[i] = 1'b1;
        d[i*XL +: XL]   = $urandom;
        r[i*RWW +: RWW] = ($urandom_range(0, 7) == 0) ? 5'd0 : RWW'($urandom_range(1, 31));
      end
      step(f, d, r, $urandom_range(0, 3) != 0);
    end
    repeat (10) idle(1'b1);

    chk("sb_queue_empty", 64'(exp_q.size()), 64'd0);
    chk("sb_write_count", 64'(n_popped), 64'(n_pushed));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
